ula_sequencial: RTL and testbench

Parametrised successor to the team's 32-bit combinational ALU. Keeps the single-cycle logic/arithmetic operations and adds shifts, signed/unsigned multiply and signed/unsigned divide. Multiply and divide run iteratively over WIDTH cycles. The block sits in the multicycle datapath's execute stage and talks to the control FSM through a start/busy/done handshake; HI/S form the 2×WIDTH product or the remainder/quotient pair for the register file's HI/LO.

---
 rtl/ula_sequencial_if.sv | 25 ++
 rtl/ula_sequencial.sv | 227 ++++++++++++++++++++++
 tb/tb_ula_sequencial.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_sequencial_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencial_if
// Brief    : Start/busy/done handshake and operand/result bus between the
//            control FSM (master) and the sequential ALU (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ula_sequencial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] HI;
    logic             Z;
    logic             V;
    logic             busy;
    logic             done;

    modport master (output start, OP, A, B, input S, HI, Z, V, busy, done);
    modport slave  (input start, OP, A, B, output S, HI, Z, V, busy, done);
endinterface
`default_nettype wire

// File: rtl/ula_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencial
// Brief    : Parametrised ALU with single-cycle logic/arithmetic/shift ops and
//            iterative (one bit per cycle) signed/unsigned multiply & divide.
// Revision : 1.0 - initial release
// ============================================================================
module ula_sequencial #(
    parameter int WIDTH = 32
) (
    input  wire             clock,
    input  wire             reset,
    ula_sequencial_if.slave bus
);
    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_XOR   = 4'b0011;
    localparam logic [3:0] c_OP_SLL   = 4'b0100;
    localparam logic [3:0] c_OP_SRL   = 4'b0101;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLT   = 4'b0111;
    localparam logic [3:0] c_OP_SRA   = 4'b1000;
    localparam logic [3:0] c_OP_MULT  = 4'b1001;
    localparam logic [3:0] c_OP_MULTU = 4'b1010;
    localparam logic [3:0] c_OP_DIV   = 4'b1011;
    localparam logic [3:0] c_OP_NOR   = 4'b1100;
    localparam logic [3:0] c_OP_DIVU  = 4'b1101;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [c_SHW-1:0] c_CNT_ONE  = c_SHW'(1);
    localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [c_SHW-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;   // negate product / quotient on final write
    logic             r_neg_r;   // negate remainder on final write
    logic [WIDTH-1:0] r_acc;     // product high half / partial remainder
    logic [WIDTH-1:0] r_mq;      // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_dvs;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_hi;
    logic             r_z;
    logic             r_v;
    logic             r_done;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [c_SHW-1:0] w_sh;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign w_sh  = bus.B[c_SHW-1:0];
    assign w_sum = bus.A + bus.B;
    assign w_dif = bus.A - bus.B;

    // Result and overflow of the one-cycle operations
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (bus.OP)
            c_OP_AND: w_res = bus.A & bus.B;
            c_OP_OR:  w_res = bus.A | bus.B;
            c_OP_XOR: w_res = bus.A ^ bus.B;
            c_OP_NOR: w_res = ~(bus.A | bus.B);
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_dif;
                w_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_dif[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            c_OP_SLL: w_res = bus.A << w_sh;
            c_OP_SRL: w_res = bus.A >> w_sh;
            c_OP_SRA: w_res = $unsigned($signed(bus.A) >>> w_sh);
            default:  w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation for multi-cycle ops (sign -> magnitude)
    // ------------------------------------------------------------------
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_sgn_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_is_mul = (bus.OP == c_OP_MULT) || (bus.OP == c_OP_MULTU);
    assign w_is_div = (bus.OP == c_OP_DIV)  || (bus.OP == c_OP_DIVU);
    assign w_sgn_op = (bus.OP == c_OP_MULT) || (bus.OP == c_OP_DIV);
    assign w_a_neg  = w_sgn_op & bus.A[WIDTH-1];
    assign w_b_neg  = w_sgn_op & bus.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (-bus.A) : bus.A;
    assign w_b_mag  = w_b_neg ? (-bus.B) : bus.B;

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shl;
    logic               w_ge;
    logic [WIDTH-1:0]   w_trial;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;

    assign w_addend = r_mq[0] ? r_dvs : '0;
    assign w_add    = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_shl    = {r_acc, r_mq[WIDTH-1]};
    assign w_ge     = (w_shl >= {1'b0, r_dvs});
    assign w_trial  = w_shl[WIDTH-1:0] - r_dvs;

    // Next accumulator / shift register value for the current iteration
    always_comb begin
        w_acc_nxt = r_acc;
        w_mq_nxt  = r_mq;
        if (r_is_div) begin
            w_acc_nxt = w_ge ? w_trial : w_shl[WIDTH-1:0];
            w_mq_nxt  = {r_mq[WIDTH-2:0], w_ge};
        end else begin
            w_acc_nxt = w_add[WIDTH:1];
            w_mq_nxt  = {w_add[0], r_mq[WIDTH-1:1]};
        end
    end

    // Sign-corrected final results. With a zero divisor the restoring loop
    // naturally yields an all-ones quotient and leaves |A| in the remainder,
    // so un-negating the remainder returns A; the quotient sign flip is
    // suppressed at accept time for that case.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod     = {w_acc_nxt, w_mq_nxt};
    assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
    assign w_quo      = r_neg_q ? (-w_mq_nxt) : w_mq_nxt;
    assign w_rem      = r_neg_r ? (-w_acc_nxt) : w_acc_nxt;

    // Control FSM, iteration state and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_dvs    <= '0;
            r_s      <= '0;
            r_hi     <= '0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (w_is_mul || w_is_div) begin
                            r_state  <= c_ST_RUN;
                            r_cnt    <= '0;
                            r_is_div <= w_is_div;
                            r_neg_q  <= (w_a_neg ^ w_b_neg) & (bus.B != '0);
                            r_neg_r  <= w_is_div & w_a_neg;
                            r_acc    <= '0;
                            r_mq     <= w_a_mag;
                            r_dvs    <= w_b_mag;
                        end else begin
                            r_s    <= w_res;
                            r_z    <= (w_res == '0);
                            r_v    <= w_ovf;
                            r_done <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_v     <= 1'b0;
                        if (r_is_div) begin
                            r_s  <= w_quo;
                            r_hi <= w_rem;
                            r_z  <= (w_quo == '0);
                        end else begin
                            r_s  <= w_prod_fix[WIDTH-1:0];
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_z  <= (w_prod_fix == '0);
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.S    = r_s;
    assign bus.HI   = r_hi;
    assign bus.Z    = r_z;
    assign bus.V    = r_v;
    assign bus.busy = (r_state == c_ST_RUN);
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ula_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_sequencial
// Brief    : Self-checking bench for ula_sequencial (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_sequencial;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [31:0] hi;
        logic        z;
        logic        v;
        logic        multi;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] hi_track;

    always #5 clock = ~clock;

    ula_sequencial_if #(.WIDTH(32)) if32 ();
    ula_sequencial_if #(.WIDTH(8))  if8  ();

    ula_sequencial #(.WIDTH(32)) u_dut32 (.clock(clock), .reset(reset), .bus(if32));
    ula_sequencial #(.WIDTH(8))  u_dut8  (.clock(clock), .reset(reset), .bus(if8));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: results straight from the arithmetic definition of each op
    function automatic void model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, output logic [31:0] s,
                                    output logic z, output logic v, output int lat);
        logic signed [63:0] sa, sb, r64;
        logic [63:0] u64;
        int sh;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sh = int'(b[4:0]);
        s = '0; v = 1'b0; lat = 0; r64 = '0;
        case (op)
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_NOR: s = ~(a | b);
            OP_ADD, OP_SUB: begin
                r64 = (op == OP_ADD) ? (sa + sb) : (sa - sb);
                s = r64[31:0];
                v = (r64 > 64'sh000000007FFFFFFF) || (r64 < -64'sh0000000080000000);
            end
            OP_SLT: s = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLL: s = a << sh;
            OP_SRL: s = a >> sh;
            OP_SRA: begin r64 = sa >>> sh; s = r64[31:0]; end
            OP_MULT: begin r64 = sa * sb; {hi, s} = r64; lat = 32; end
            OP_MULTU: begin u64 = {32'b0, a} * {32'b0, b}; {hi, s} = u64; lat = 32; end
            OP_DIV: begin
                lat = 32;
                if (b == 0) begin s = '1; hi = a; end
                else begin r64 = sa / sb; s = r64[31:0]; r64 = sa % sb; hi = r64[31:0]; end
            end
            OP_DIVU: begin
                lat = 32;
                if (b == 0) begin s = '1; hi = a; end
                else begin s = a / b; hi = a % b; end
            end
            default: s = '0;
        endcase
        z = (op == OP_MULT || op == OP_MULTU) ? ({hi, s} == 64'd0) : (s == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'h7FFFFFFF;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request on the 32-bit DUT and wait (bounded) for done
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok, output logic hold_ok);
        logic [31:0] s0, h0;
        @(negedge clock);
        s0 = if32.S; h0 = if32.HI;
        if32.start = 1'b1; if32.OP = op; if32.A = a; if32.B = b;
        @(posedge clock); #1;
        if32.start = 1'b0; if32.OP = 4'($urandom); if32.A = $urandom; if32.B = $urandom;
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!if32.done && lat < 100) begin
            if (!if32.busy) busy_ok = 1'b0;
            if (if32.S !== s0 || if32.HI !== h0) hold_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic apply32(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] es, input logic [31:0] ehi, input logic ez, input logic ev,
                           input int elat);
        int lat;
        logic bok, hok;
        run32(op, a, b, lat, bok, hok);
        chk($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
        chk($sformatf("%s_S", tag), 64'(if32.S), 64'(es));
        chk($sformatf("%s_HI", tag), 64'(if32.HI), 64'(ehi));
        chk($sformatf("%s_ZV", tag), {62'b0, if32.Z, if32.V}, {62'b0, ez, ev});
        chk($sformatf("%s_busy_run", tag), {62'b0, if32.busy, bok}, {62'b0, 1'b0, 1'b1});
        chk($sformatf("%s_hold", tag), 64'(hok), 64'(1));
        @(posedge clock); #1;
        chk($sformatf("%s_donepulse", tag), 64'(if32.done), 64'(0));
    endtask

    task automatic apply8(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic [7:0] ehi, input logic ez, input logic ev,
                          input int elat);
        int lat;
        @(negedge clock);
        if8.start = 1'b1; if8.OP = op; if8.A = a; if8.B = b;
        @(posedge clock); #1;
        if8.start = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom);
        lat = 0;
        while (!if8.done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
        chk($sformatf("%s_S_HI", tag), {48'b0, if8.HI, if8.S}, {48'b0, ehi, es});
        chk($sformatf("%s_ZV", tag), {62'b0, if8.Z, if8.V}, {62'b0, ez, ev});
    endtask

    vec_t        tbl[$];
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, r_s, r_hi;
    logic        r_z, r_v, bok, seen;
    int          r_lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if32.start = 1'b0; if32.OP = '0; if32.A = '0; if32.B = '0;
        if8.start  = 1'b0; if8.OP  = '0; if8.A  = '0; if8.B  = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_S_HI", {if32.HI, if32.S}, 64'd0);
        chk("reset_flags", {60'b0, if32.Z, if32.V, if32.busy, if32.done}, 64'd0);
        chk("reset8", {44'b0, if8.HI, if8.S, if8.Z, if8.V, if8.busy, if8.done}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        hi_track = '0;

        // ---------------- directed vectors ----------------
        tbl.push_back('{OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0});
        tbl.push_back('{OP_SUB,   32'h5,        32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        tbl.push_back('{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SRA,   32'h80000000, 32'h4,        32'hF8000000, 32'h0,        1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_MULTU, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'h00000002, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF, 32'h7,        1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_SUB,   32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0});
        tbl.push_back('{OP_NOR,   32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SLL,   32'h1,        32'h23,       32'h8,        32'h0,        1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SRL,   32'h80000000, 32'h1F,       32'h1,        32'h0,        1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'b1110,  32'hFFFF,     32'h1234,     32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        tbl.push_back('{OP_MULT,  32'h0,        32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1});
        tbl.push_back('{OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        tbl.push_back('{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b1});
        tbl.push_back('{OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        tbl.push_back('{OP_MULTU, 32'h10000,    32'h10000,    32'h0,        32'h1,        1'b0, 1'b0, 1'b1});
        foreach (tbl[i]) begin
            r_hi = tbl[i].multi ? tbl[i].hi : hi_track;
            apply32($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s, r_hi,
                    tbl[i].z, tbl[i].v, tbl[i].multi ? 32 : 0);
            hi_track = r_hi;
        end

        // ---------------- MULT with ignored start mid-run ----------------
        @(negedge clock);
        if32.start = 1'b1; if32.OP = OP_MULT; if32.A = 32'hFFFFFFFE; if32.B = 32'h3;
        @(posedge clock); #1;
        if32.start = 1'b0;
        bok = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(negedge clock);
            if (e == 5) begin
                if32.start = 1'b1; if32.OP = OP_ADD; if32.A = 32'h1; if32.B = 32'h2;
            end else if (e == 6) begin
                if32.start = 1'b0; if32.A = $urandom; if32.B = $urandom;
            end else if (e == 32) begin
                if32.start = 1'b1; if32.OP = OP_ADD; if32.A = 32'h1; if32.B = 32'h1;
            end
            @(posedge clock); #1;
            if (e < 32 && (!if32.busy || if32.done)) bok = 1'b0;
        end
        chk("midrun_busy", 64'(bok), 64'(1));
        chk("midrun_result", {if32.HI, if32.S}, 64'hFFFFFFFF_FFFFFFFA);
        chk("midrun_done", {62'b0, if32.done, if32.busy}, {62'b0, 1'b1, 1'b0});
        hi_track = 32'hFFFFFFFF;
        @(posedge clock); #1;
        chk("accept_after_fall", 64'(if32.S), 64'h2);

        // ---------------- back-to-back single-cycle ops ----------------
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if32.start = 1'b1; if32.OP = OP_ADD; if32.A = 32'(i * 3); if32.B = 32'(i * 1000);
            @(posedge clock); #1;
            chk($sformatf("b2b%0d", i), {31'b0, if32.done, if32.S}, {31'b0, 1'b1, 32'(i * 1003)});
        end
        @(negedge clock);
        if32.start = 1'b0;
        @(posedge clock); #1;
        chk("b2b_done_drop", 64'(if32.done), 64'(0));
        chk("b2b_hi_hold", 64'(if32.HI), 64'(hi_track));

        // ---------------- reset during DIV ----------------
        @(negedge clock);
        if32.start = 1'b1; if32.OP = OP_DIV; if32.A = 32'd100; if32.B = 32'd7;
        @(posedge clock); #1;
        if32.start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_S_HI", {if32.HI, if32.S}, 64'd0);
        chk("abort_flags", {60'b0, if32.Z, if32.V, if32.busy, if32.done}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (if32.done || if32.busy) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        hi_track = '0;

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 150; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = pick();
            r_b  = pick();
            if ((r_op == OP_DIV || r_op == OP_DIVU) && $urandom_range(0, 5) == 0) r_b = '0;
            r_hi = hi_track;
            model32(r_op, r_a, r_b, r_hi, r_s, r_z, r_v, r_lat);
            apply32($sformatf("rnd%0d_op%0h", i, r_op), r_op, r_a, r_b, r_s, r_hi, r_z, r_v, r_lat);
            hi_track = r_hi;
        end

        // ---------------- WIDTH = 8 instance ----------------
        apply8("w8_add",  OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 0);
        apply8("w8_mult", OP_MULT, 8'hFE, 8'h03, 8'hFA, 8'hFF, 1'b0, 1'b0, 8);
        apply8("w8_divu", OP_DIVU, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);
        apply8("w8_div",  OP_DIV,  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 8);
        apply8("w8_sll",  OP_SLL,  8'h01, 8'h0B, 8'h08, 8'h00, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
